vcache_ctrl: RTL and testbench

//  Controller for the fully-associative victim cache between L1 and physical memory.

---
 rtl/vcache_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_vcache_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vcache_ctrl.sv
// Fully-associative victim cache controller: tag/valid/dirty bookkeeping, FIFO
// replacement, L1 swap handshake and pmem fill/writeback sequencing.
module vcache_ctrl #(
  parameter int NUM_ENTRIES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       l1_read,
  input  logic                       l1_write,
  input  logic [31:0]                l1_address,
  input  logic [255:0]               l1_wdata,
  input  logic                       l1_wdirty,
  output logic [255:0]               l1_rdata,
  output logic                       l1_rdirty,
  output logic                       l1_resp,
  output logic                       pmem_read,
  output logic                       pmem_write,
  output logic [31:0]                pmem_address,
  output logic [255:0]               pmem_wdata,
  input  logic [255:0]               pmem_rdata,
  input  logic                       pmem_resp,
  output logic [NUM_ENTRIES*32-1:0]  data_we,
  output logic [255:0]               data_in,
  input  logic [NUM_ENTRIES*256-1:0] data_out
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HIT_RD    = 3'd1,
    MEM_RD    = 3'd2,
    WRITEBACK = 3'd3,
    INSERT    = 3'd4
  } state_t;

  state_t state, next_state;

  logic [NUM_ENTRIES-1:0] valid;
  logic [NUM_ENTRIES-1:0] dirty;
  logic [26:0]            tag [NUM_ENTRIES];
  logic [IDX_W-1:0]       fifo_ptr;
  logic [IDX_W-1:0]       target;
  logic                   target_hit;

  logic [26:0]            req_tag;
  logic                   hit_any;
  logic [IDX_W-1:0]       hit_idx;
  logic                   free_any;
  logic [IDX_W-1:0]       free_idx;
  logic [IDX_W-1:0]       alloc_idx;
  logic [255:0]           line [NUM_ENTRIES];

  assign req_tag = l1_address[31:5];

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_line
    assign line[g] = data_out[256*g +: 256];
  end

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
      if (valid[e] && (tag[e] == req_tag)) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(e);
      end else begin
        hit_any = hit_any;
      end
      if (!valid[e]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(e);
      end else begin
        free_any = free_any;
      end
    end
    if (hit_any) begin
      alloc_idx = hit_idx;
    end else if (free_any) begin
      alloc_idx = free_idx;
    end else begin
      alloc_idx = fifo_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (l1_write) begin
          if (valid[alloc_idx] && dirty[alloc_idx] && !hit_any) begin
            next_state = WRITEBACK;
          end else begin
            next_state = INSERT;
          end
        end else if (l1_read) begin
          next_state = hit_any ? HIT_RD : MEM_RD;
        end else begin
          next_state = IDLE;
        end
      end
      HIT_RD:    next_state = IDLE;
      MEM_RD:    next_state = pmem_resp ? IDLE : MEM_RD;
      WRITEBACK: next_state = pmem_resp ? INSERT : WRITEBACK;
      INSERT:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // The victim choice is latched in IDLE; the FIFO pointer only advances on a real eviction.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= '0;
      dirty      <= '0;
      fifo_ptr   <= '0;
      target     <= '0;
      target_hit <= 1'b0;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        tag[e] <= 27'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (l1_write) begin
            target     <= alloc_idx;
            target_hit <= hit_any;
            if (!hit_any && !free_any) begin
              fifo_ptr <= fifo_ptr + 1'b1;
            end
          end else if (l1_read) begin
            target <= hit_idx;
          end
        end
        HIT_RD: begin
          valid[target] <= 1'b0;
        end
        INSERT: begin
          tag[target]   <= req_tag;
          valid[target] <= 1'b1;
          dirty[target] <= l1_wdirty | (target_hit & dirty[target]);
        end
        default: begin
          valid <= valid;
        end
      endcase
    end
  end

  always_comb begin
    l1_rdata     = 256'd0;
    l1_rdirty    = 1'b0;
    l1_resp      = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 32'd0;
    pmem_wdata   = 256'd0;
    data_we      = '0;
    data_in      = l1_wdata;
    case (state)
      HIT_RD: begin
        l1_rdata  = line[target];
        l1_rdirty = dirty[target];
        l1_resp   = 1'b1;
      end
      MEM_RD: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, 5'b00000};
        if (pmem_resp) begin
          l1_rdata = pmem_rdata;
          l1_resp  = 1'b1;
        end else begin
          l1_resp  = 1'b0;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag[target], 5'b00000};
        pmem_wdata   = line[target];
      end
      INSERT: begin
        l1_resp = 1'b1;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
          if (IDX_W'(e) == target) begin
            data_we[32*e +: 32] = 32'hFFFF_FFFF;
          end else begin
            data_we[32*e +: 32] = 32'h0000_0000;
          end
        end
      end
      default: begin
        l1_resp = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_vcache_ctrl.sv
// Directed bench for vcache_ctrl with a behavioural per-entry line store and
// a hand-driven pmem responder.
module tb_vcache_ctrl;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           l1_read = 1'b0;
  logic           l1_write = 1'b0;
  logic [31:0]    l1_address = 32'd0;
  logic [255:0]   l1_wdata = 256'd0;
  logic           l1_wdirty = 1'b0;
  logic [255:0]   l1_rdata;
  logic           l1_rdirty;
  logic           l1_resp;
  logic           pmem_read;
  logic           pmem_write;
  logic [31:0]    pmem_address;
  logic [255:0]   pmem_wdata;
  logic [255:0]   pmem_rdata = 256'd0;
  logic           pmem_resp = 1'b0;
  logic [N*32-1:0]  data_we;
  logic [255:0]     data_in;
  logic [N*256-1:0] data_out;

  logic [255:0] store [N];

  int checks = 0;
  int failures = 0;

  vcache_ctrl #(.NUM_ENTRIES(N)) dut (
    .clk(clk), .rst(rst),
    .l1_read(l1_read), .l1_write(l1_write), .l1_address(l1_address),
    .l1_wdata(l1_wdata), .l1_wdirty(l1_wdirty),
    .l1_rdata(l1_rdata), .l1_rdirty(l1_rdirty), .l1_resp(l1_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .data_we(data_we), .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  // Byte-enabled line storage, one array per entry.
  always @(posedge clk) begin
    for (int e = 0; e < N; e++) begin
      for (int b = 0; b < 32; b++) begin
        if (data_we[32*e + b]) store[e][8*b +: 8] <= data_in[8*b +: 8];
      end
    end
  end

  always_comb begin
    for (int e = 0; e < N; e++) data_out[256*e +: 256] = store[e];
  end

  task automatic check_eq(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk(input logic [31:0] k);
    return {8{k ^ 32'hC0DE_0000}};
  endfunction

  function automatic logic [255:0] we_for(input int entry);
    logic [255:0] v;
    v = 256'd0;
    v[32*entry +: 32] = 32'hFFFF_FFFF;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    l1_read = 1'b0; l1_write = 1'b0; pmem_resp = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
  endtask

  task automatic rd_miss(input string name, input logic [31:0] addr, input logic [255:0] pdata);
    l1_read = 1'b1; l1_address = addr;
    #1 check_eq({name, "_idle_pread"}, 256'(pmem_read), 256'd0);
    cyc();
    check_eq({name, "_pread"}, 256'(pmem_read), 256'd1);
    check_eq({name, "_paddr"}, 256'(pmem_address), 256'({addr[31:5], 5'b00000}));
    check_eq({name, "_noresp"}, 256'(l1_resp), 256'd0);
    cyc();
    pmem_resp = 1'b1; pmem_rdata = pdata;
    #1;
    check_eq({name, "_resp"}, 256'(l1_resp), 256'd1);
    check_eq({name, "_rdata"}, l1_rdata, pdata);
    check_eq({name, "_rdirty"}, 256'(l1_rdirty), 256'd0);
    cyc();
    pmem_resp = 1'b0; l1_read = 1'b0;
    #1 check_eq({name, "_pread_off"}, 256'(pmem_read), 256'd0);
  endtask

  task automatic rd_hit(input string name, input logic [31:0] addr, input logic [255:0] exp_data,
                        input logic exp_dirty);
    l1_read = 1'b1; l1_address = addr;
    #1 check_eq({name, "_idle_resp"}, 256'(l1_resp), 256'd0);
    cyc();
    check_eq({name, "_resp"}, 256'(l1_resp), 256'd1);
    check_eq({name, "_rdata"}, l1_rdata, exp_data);
    check_eq({name, "_rdirty"}, 256'(l1_rdirty), 256'(exp_dirty));
    check_eq({name, "_pread"}, 256'(pmem_read), 256'd0);
    cyc();
    l1_read = 1'b0;
    #1;
  endtask

  task automatic wr(input string name, input logic [31:0] addr, input logic [255:0] d, input logic dty,
                    input logic exp_wb, input logic [31:0] wb_addr, input logic [255:0] wb_data,
                    input int entry);
    l1_write = 1'b1; l1_address = addr; l1_wdata = d; l1_wdirty = dty;
    #1 check_eq({name, "_idle_resp"}, 256'(l1_resp), 256'd0);
    cyc();
    if (exp_wb) begin
      check_eq({name, "_pwrite"}, 256'(pmem_write), 256'd1);
      check_eq({name, "_wbaddr"}, 256'(pmem_address), 256'(wb_addr));
      check_eq({name, "_wbdata"}, pmem_wdata, wb_data);
      check_eq({name, "_wb_we"}, 256'(data_we), 256'd0);
      cyc();
      pmem_resp = 1'b1;
      cyc();
      pmem_resp = 1'b0;
      #1;
    end else begin
      check_eq({name, "_nopwrite"}, 256'(pmem_write), 256'd0);
    end
    check_eq({name, "_we"}, 256'(data_we), we_for(entry));
    check_eq({name, "_din"}, data_in, d);
    check_eq({name, "_resp"}, 256'(l1_resp), 256'd1);
    cyc();
    l1_write = 1'b0;
    #1 check_eq({name, "_resp_off"}, 256'(l1_resp), 256'd0);
  endtask

  initial begin
    for (int e = 0; e < N; e++) store[e] = 256'd0;
    do_reset();
    check_eq("rst_resp", 256'(l1_resp), 256'd0);
    check_eq("rst_pread", 256'(pmem_read), 256'd0);
    check_eq("rst_pwrite", 256'(pmem_write), 256'd0);
    check_eq("rst_paddr", 256'(pmem_address), 256'd0);
    check_eq("rst_we", 256'(data_we), 256'd0);
    check_eq("rst_valid", 256'(dut.valid), 256'd0);
    check_eq("rst_fifo", 256'(dut.fifo_ptr), 256'd0);

    // Read miss served from pmem.
    rd_miss("t1", 32'h0000_0100, mk(32'h100));

    // Insert clean, hit it, then it is gone.
    wr("t2w", 32'h0000_1000, mk(32'hD), 1'b0, 1'b0, 32'd0, 256'd0, 0);
    rd_hit("t2h", 32'h0000_1000, mk(32'hD), 1'b0);
    rd_miss("t2m", 32'h0000_1000, mk(32'h1000));

    // Dirty FIFO eviction with writeback.
    do_reset();
    for (int i = 0; i < 4; i++)
      wr("t3f", 32'(i * 32), mk(32'(i)), 1'b1, 1'b0, 32'd0, 256'd0, i);
    wr("t3e0", 32'h80, mk(32'h80), 1'b1, 1'b1, 32'h0, mk(32'd0), 0);
    check_eq("t3_fifo1", 256'(dut.fifo_ptr), 256'd1);
    wr("t3e1", 32'hA0, mk(32'hA0), 1'b0, 1'b1, 32'h20, mk(32'd1), 1);
    check_eq("t3_fifo2", 256'(dut.fifo_ptr), 256'd2);
    rd_hit("t3h", 32'h80, mk(32'h80), 1'b1);

    // Clean FIFO eviction: no writeback.
    do_reset();
    for (int i = 0; i < 4; i++)
      wr("t4f", 32'(i * 32), mk(32'(i + 16)), 1'b0, 1'b0, 32'd0, 256'd0, i);
    wr("t4e0", 32'h80, mk(32'h4080), 1'b0, 1'b0, 32'd0, 256'd0, 0);
    check_eq("t4_fifo1", 256'(dut.fifo_ptr), 256'd1);

    // Simultaneous read and write: the write goes first, evicting entry1 (0x20).
    l1_read = 1'b1; l1_write = 1'b1; l1_address = 32'h200;
    l1_wdata = mk(32'h200); l1_wdirty = 1'b0;
    #1 check_eq("t5_idle_resp", 256'(l1_resp), 256'd0);
    cyc();
    check_eq("t5_we", 256'(data_we), we_for(1));
    check_eq("t5_resp_w", 256'(l1_resp), 256'd1);
    check_eq("t5_pread", 256'(pmem_read), 256'd0);
    cyc();
    l1_write = 1'b0;
    #1;
    cyc();
    check_eq("t5_resp_r", 256'(l1_resp), 256'd1);
    check_eq("t5_rdata", l1_rdata, mk(32'h200));
    cyc();
    l1_read = 1'b0;
    #1;
    rd_miss("t5m", 32'h20, mk(32'h20));

    // Reset in the middle of a writeback.
    do_reset();
    for (int i = 0; i < 4; i++)
      wr("t6f", 32'(i * 32), mk(32'(i + 32)), 1'b1, 1'b0, 32'd0, 256'd0, i);
    l1_write = 1'b1; l1_address = 32'h80; l1_wdata = mk(32'h680); l1_wdirty = 1'b1;
    cyc();
    check_eq("t6_pwrite", 256'(pmem_write), 256'd1);
    rst = 1'b1;
    cyc();
    check_eq("t6_pwrite_off", 256'(pmem_write), 256'd0);
    check_eq("t6_resp_off", 256'(l1_resp), 256'd0);
    check_eq("t6_valid", 256'(dut.valid), 256'd0);
    rst = 1'b0; l1_write = 1'b0;
    cyc();
    rd_miss("t6m", 32'h0, mk(32'h600));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
